avlmm_arbiter: RTL and testbench
================================

Name: avlmm_arbiter

Overview:
- Two-host to one-agent Avalon-MM arbiter for the shared SDRAM port of the video controller.
- Host 0 is the stream-to-memory write bridge (frame capture). Host 1 is the display read DMA.
- Arbitrates per burst: grant is locked until every write beat or the read command is accepted.
- Routes read data back to the issuing host through an in-order pending-read queue.

Parameters:
- ADDR_WIDTH, 32, address width (byte address).
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
- BURST_WIDTH, 6, burstcount width.
- MAX_PENDING, 4, maximum outstanding read bursts tracked.
- PRIORITY, 0, arbitration policy: 0 = round-robin, 1 = host 1 fixed priority.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- hN_address  in  ADDR_WIDTH  host N address (N = 0, 1; same for all hN_ lines).
- hN_burstcount  in  BURST_WIDTH  host N burst length, valid on first beat/command.
- hN_write, hN_read  in  1 each  host N requests.
- hN_writedata  in  DATA_WIDTH  host N write beat.
- hN_byteenable  in  DATA_WIDTH/8  host N byte enables.
- hN_waitrequest  out  1  stall to host N.
- hN_readdata  out  DATA_WIDTH  m_readdata broadcast to both hosts.
- hN_readdatavalid  out  1  read beat belongs to host N.
- m_address, m_burstcount, m_write, m_read, m_writedata, m_byteenable  out  as host widths  agent command.
- m_waitrequest  in  1  agent stall.
- m_readdata  in  DATA_WIDTH  agent read data.
- m_readdatavalid  in  1  agent read beat.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - State IDLE; all m_* command outputs 0; hN_waitrequest 1; hN_readdatavalid 0; err 0.
  - Last-grant pointer = 1, so host 0 wins the first tie. Pending queue empty.
  - Reset is asynchronous: asserting reset_n mid-burst deasserts m_write/m_read immediately. Beat counter and queue clear.
- IDLE:
  - Command outputs 0; both hN_waitrequest 1.
  - A request is hN_write, or hN_read while the pending queue is not full.
  - Winner is registered (grant index, 1 bit). State goes to WR_BURST if the winner's write is set, else RD_CMD. One idle cycle between bursts.
  - Arbitration: PRIORITY=1 gives host 1 priority. PRIORITY=0 grants the host that was not last granted when both request.
  - A host asserting read and write together: write wins, err set.
- WR_BURST:
  - Granted host's command and data are muxed to m_*; its hN_waitrequest = m_waitrequest; other host waitrequest 1.
  - A beat is accepted when m_write && !m_waitrequest.
  - On the first accepted beat, beat counter loads hN_burstcount; 0 is treated as 1.
  - Each accepted beat decrements the counter. The last accepted beat returns to IDLE and updates the last-grant pointer.
  - m_address and m_burstcount are passed as the host drives them. Host-side zeroing after the first beat is tolerated.
- RD_CMD:
  - Granted read is forwarded.
  - On m_read && !m_waitrequest: push {owner, burstcount (0->1)} into the queue; go to IDLE; update the pointer.
- Read return, concurrent with any state:
  - On m_readdatavalid, drive hN_readdatavalid=1 for the queue-head owner in the same cycle (combinational).
  - A return counter loads the head burstcount and decrements per beat. The last beat pops the head.
  - A push and pop in the same cycle are both honoured.
  - m_readdatavalid with the queue empty: beat dropped, err set.
- err:
  - Sticky until reset.
  - Set by read+write conflict, orphan read data, or hN_burstcount > 2^BURST_WIDTH-1 after 0->1 mapping (unreachable; assertion only).
- Latency:
  - Request to first agent command: 1 cycle.
  - Read data to host: 0 cycles.

Decomposition:
- Package avlmm_arb_pkg holds:
  - state enum {IDLE, WR_BURST, RD_CMD};
  - owner_t (1 bit);
  - pending entry struct {owner_t owner; logic [BURST_WIDTH-1:0] len}.
- Pending queue: instantiate existing sync_fifo with width 1+BURST_WIDTH and depth MAX_PENDING, using its full flag for read gating. The sync_fifo reset is driven with !reset_n, and the wrapper must preserve async clear of the grant and counter registers.

Test Plan:
- Host 0 writes burst of 8 at 0x100, agent never stalls -> m_write high 8 cycles, data in order, IDLE after beat 8, h1_waitrequest stays 1.
- Both hosts request simultaneously from reset, PRIORITY=0 -> host 0 burst first, then host 1 after 1 idle cycle; repeat -> alternation 0,1,0,1.
- PRIORITY=1, host 0 write of 8 beats mid-burst while host 1 requests read -> host 0 burst completes uninterrupted (8 beats), then host 1 read granted.
- Host 1 issues 4 read bursts of 8 (MAX_PENDING=4), agent returns 32 beats late -> fifth read stalled until first return burst completes; h1_readdatavalid count 32, h0_readdatavalid 0.
- Interleaved reads: h0 read len 2, then h1 read len 3 -> returns route 2 beats to h0 then 3 to h1.
- Agent waitrequest random 50% during write burst of 8 -> exactly 8 accepted beats. Reset_n pulse mid-burst -> m_write 0 same cycle, err 0, queue empty. m_readdatavalid with empty queue -> err=1 and stays 1.

Source files
------------

// File: rtl/avlmm_arb_pkg.sv
// Shared types for the two-host Avalon-MM SDRAM port arbiter.
package avlmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_CMD
  } state_t;

  typedef logic owner_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push while full is honoured only with a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/avlmm_arbiter.sv
// Two-host to one-agent Avalon-MM arbiter: per-burst grant locking and in-order read-data routing.
module avlmm_arbiter
  import avlmm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 6,
  parameter int MAX_PENDING = 4,
  parameter int PRIORITY    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     h0_address,
  input  logic [BURST_WIDTH-1:0]    h0_burstcount,
  input  logic                      h0_write,
  input  logic                      h0_read,
  input  logic [DATA_WIDTH-1:0]     h0_writedata,
  input  logic [DATA_WIDTH/8-1:0]   h0_byteenable,
  output logic                      h0_waitrequest,
  output logic [DATA_WIDTH-1:0]     h0_readdata,
  output logic                      h0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]     h1_address,
  input  logic [BURST_WIDTH-1:0]    h1_burstcount,
  input  logic                      h1_write,
  input  logic                      h1_read,
  input  logic [DATA_WIDTH-1:0]     h1_writedata,
  input  logic [DATA_WIDTH/8-1:0]   h1_byteenable,
  output logic                      h1_waitrequest,
  output logic [DATA_WIDTH-1:0]     h1_readdata,
  output logic                      h1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]     m_address,
  output logic [BURST_WIDTH-1:0]    m_burstcount,
  output logic                      m_write,
  output logic                      m_read,
  output logic [DATA_WIDTH-1:0]     m_writedata,
  output logic [DATA_WIDTH/8-1:0]   m_byteenable,
  input  logic                      m_waitrequest,
  input  logic [DATA_WIDTH-1:0]     m_readdata,
  input  logic                      m_readdatavalid,
  output logic                      err
);

  typedef struct packed {
    owner_t                 owner;
    logic [BURST_WIDTH-1:0] len;
  } pend_entry_t;

  localparam logic [BURST_WIDTH:0] MAX_LEN = {1'b0, {BURST_WIDTH{1'b1}}};

  state_t                 state, state_nxt;
  owner_t                 grant, last_grant, win;
  logic                   req0, req1, win_write;
  logic                   wr_active, ret_active;
  logic [BURST_WIDTH-1:0] wr_left, ret_left, wr_remaining, ret_remaining;
  logic                   wr_beat, wr_last, rd_accept, ret_beat;
  logic                   q_full, q_empty, q_pop;
  pend_entry_t            push_entry, head;

  logic                   g_write, g_read;
  logic [ADDR_WIDTH-1:0]  g_address;
  logic [BURST_WIDTH-1:0] g_burstcount, g_len;
  logic [DATA_WIDTH-1:0]  g_writedata;
  logic [DATA_WIDTH/8-1:0] g_byteenable;

  // Granted-host view of the command lines.
  assign g_write      = grant ? h1_write      : h0_write;
  assign g_read       = grant ? h1_read       : h0_read;
  assign g_address    = grant ? h1_address    : h0_address;
  assign g_burstcount = grant ? h1_burstcount : h0_burstcount;
  assign g_writedata  = grant ? h1_writedata  : h0_writedata;
  assign g_byteenable = grant ? h1_byteenable : h0_byteenable;
  assign g_len        = (g_burstcount == '0) ? BURST_WIDTH'(1) : g_burstcount;

  assign wr_beat      = (state == WR_BURST) && g_write && !m_waitrequest;
  assign wr_remaining = wr_active ? wr_left : g_len;
  assign wr_last      = wr_beat && (wr_remaining == BURST_WIDTH'(1));
  assign rd_accept    = (state == RD_CMD) && g_read && !m_waitrequest;

  // Reads only compete while the return queue can still take their entry.
  assign req0 = h0_write || (h0_read && !q_full);
  assign req1 = h1_write || (h1_read && !q_full);

  always_comb begin
    win = 1'b0;
    if (PRIORITY == 1)       win = req1;
    else if (req0 && req1)   win = ~last_grant;
    else                     win = req1;
  end

  // A host raising read and write together is treated as a write.
  assign win_write = win ? h1_write : h0_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (req0 || req1) state_nxt = win_write ? WR_BURST : RD_CMD;
      WR_BURST: if (wr_last)      state_nxt = IDLE;
      RD_CMD:   if (rd_accept)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_address      = '0;
    m_burstcount   = '0;
    m_write        = 1'b0;
    m_read         = 1'b0;
    m_writedata    = '0;
    m_byteenable   = '0;
    h0_waitrequest = 1'b1;
    h1_waitrequest = 1'b1;
    unique case (state)
      WR_BURST: begin
        m_write      = g_write;
        m_address    = g_address;
        m_burstcount = g_burstcount;
        m_writedata  = g_writedata;
        m_byteenable = g_byteenable;
      end
      RD_CMD: begin
        m_read       = g_read;
        m_address    = g_address;
        m_burstcount = g_burstcount;
        m_byteenable = g_byteenable;
      end
      default: ;
    endcase
    if (state != IDLE) begin
      if (grant) h1_waitrequest = m_waitrequest;
      else       h0_waitrequest = m_waitrequest;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wr_active  <= 1'b0;
      wr_left    <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) grant <= win;
      if (wr_last || rd_accept)            last_grant <= grant;
      if (wr_beat) begin
        wr_active <= !wr_last;
        wr_left   <= wr_remaining - 1'b1;
      end
    end
  end

  // Read return: the queue head owns every beat until its length is used up.
  assign push_entry       = '{owner: grant, len: g_len};
  assign ret_beat         = m_readdatavalid && !q_empty;
  assign ret_remaining    = ret_active ? ret_left : head.len;
  assign q_pop            = ret_beat && (ret_remaining == BURST_WIDTH'(1));
  assign h0_readdatavalid = ret_beat && (head.owner == 1'b0);
  assign h1_readdatavalid = ret_beat && (head.owner == 1'b1);
  assign h0_readdata      = m_readdata;
  assign h1_readdata      = m_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_active <= 1'b0;
      ret_left   <= '0;
      err        <= 1'b0;
    end else begin
      if (ret_beat) begin
        ret_active <= !q_pop;
        ret_left   <= ret_remaining - 1'b1;
      end
      if ((h0_read && h0_write) || (h1_read && h1_write) || (m_readdatavalid && q_empty))
        err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (1 + BURST_WIDTH),
    .DEPTH (MAX_PENDING)
  ) u_pending (
    .clk   (clk),
    .rst   (!reset_n),
    .push  (rd_accept),
    .wdata (push_entry),
    .pop   (q_pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  a_len_fits: assert property (@(posedge clk) disable iff (!reset_n)
    (state != IDLE) |-> ({1'b0, g_len} <= MAX_LEN));

endmodule

// File: tb/tb_avlmm_arbiter.sv
// Directed bench for avlmm_arbiter: round-robin and host-1-priority instances share one stimulus.
module tb_avlmm_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  h_write = '0, h_read = '0;
  logic [31:0] h_addr  [2] = '{default: '0};
  logic [5:0]  h_bc    [2] = '{default: '0};
  logic [31:0] h_wdata [2] = '{default: '0};
  logic [3:0]  h_be    [2] = '{default: '0};
  logic        m_wait = 1'b0, m_rdv = 1'b0;
  logic [31:0] m_rdata = '0;

  wire [1:0]  r_hw, p_hw, r_hv, p_hv;
  wire [31:0] r_rd0, r_rd1, p_rd0, p_rd1, r_ma, p_ma, r_mwd, p_mwd;
  wire [5:0]  r_mbc, p_mbc;
  wire [3:0]  r_mbe, p_mbe;
  wire        r_mw, p_mw, r_mr, p_mr, r_err, p_err;

  wire [1:0]  h_wait    = sel ? p_hw  : r_hw;
  wire [1:0]  h_rdv     = sel ? p_hv  : r_hv;
  wire [31:0] h0_rdata  = sel ? p_rd0 : r_rd0;
  wire [31:0] h1_rdata  = sel ? p_rd1 : r_rd1;
  wire [31:0] m_address = sel ? p_ma  : r_ma;
  wire [31:0] m_wdata   = sel ? p_mwd : r_mwd;
  wire [5:0]  m_bc      = sel ? p_mbc : r_mbc;
  wire [3:0]  m_be      = sel ? p_mbe : r_mbe;
  wire        m_write   = sel ? p_mw  : r_mw;
  wire        m_read    = sel ? p_mr  : r_mr;
  wire        err       = sel ? p_err : r_err;

  avlmm_arbiter #(.PRIORITY(0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .h0_address(h_addr[0]), .h0_burstcount(h_bc[0]), .h0_write(h_write[0]), .h0_read(h_read[0]),
    .h0_writedata(h_wdata[0]), .h0_byteenable(h_be[0]), .h0_waitrequest(r_hw[0]),
    .h0_readdata(r_rd0), .h0_readdatavalid(r_hv[0]),
    .h1_address(h_addr[1]), .h1_burstcount(h_bc[1]), .h1_write(h_write[1]), .h1_read(h_read[1]),
    .h1_writedata(h_wdata[1]), .h1_byteenable(h_be[1]), .h1_waitrequest(r_hw[1]),
    .h1_readdata(r_rd1), .h1_readdatavalid(r_hv[1]),
    .m_address(r_ma), .m_burstcount(r_mbc), .m_write(r_mw), .m_read(r_mr),
    .m_writedata(r_mwd), .m_byteenable(r_mbe), .m_waitrequest(m_wait),
    .m_readdata(m_rdata), .m_readdatavalid(m_rdv), .err(r_err)
  );

  avlmm_arbiter #(.PRIORITY(1)) dut_pri (
    .clk(clk), .reset_n(reset_n),
    .h0_address(h_addr[0]), .h0_burstcount(h_bc[0]), .h0_write(h_write[0]), .h0_read(h_read[0]),
    .h0_writedata(h_wdata[0]), .h0_byteenable(h_be[0]), .h0_waitrequest(p_hw[0]),
    .h0_readdata(p_rd0), .h0_readdatavalid(p_hv[0]),
    .h1_address(h_addr[1]), .h1_burstcount(h_bc[1]), .h1_write(h_write[1]), .h1_read(h_read[1]),
    .h1_writedata(h_wdata[1]), .h1_byteenable(h_be[1]), .h1_waitrequest(p_hw[1]),
    .h1_readdata(p_rd1), .h1_readdatavalid(p_hv[1]),
    .m_address(p_ma), .m_burstcount(p_mbc), .m_write(p_mw), .m_read(p_mr),
    .m_writedata(p_mwd), .m_byteenable(p_mbe), .m_waitrequest(m_wait),
    .m_readdata(m_rdata), .m_readdatavalid(m_rdv), .err(p_err)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, cyc = 0;
  int wr_cyc[$], rd_cyc[$], rv_cyc[$], rv_host[$];
  logic [31:0] wr_log[$], wa_log[$], rd_log[$], rv_data[$];
  logic [5:0]  wb_log[$];
  logic [3:0]  we_log[$];
  int wr_hi_cnt = 0, h1_unwait = 0;

  always @(posedge clk) cyc++;

  // Agent-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_write) wr_hi_cnt++;
    if (!h_wait[1]) h1_unwait++;
    if (m_write && !m_wait) begin
      wr_log.push_back(m_wdata); wa_log.push_back(m_address);
      wb_log.push_back(m_bc); we_log.push_back(m_be); wr_cyc.push_back(cyc);
    end
    if (m_read && !m_wait) begin rd_log.push_back(m_address); rd_cyc.push_back(cyc); end
    if (h_rdv[0]) begin rv_host.push_back(0); rv_data.push_back(h0_rdata); rv_cyc.push_back(cyc); end
    if (h_rdv[1]) begin rv_host.push_back(1); rv_data.push_back(h1_rdata); rv_cyc.push_back(cyc); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0;
    h_write = '0; h_read = '0; m_wait = 1'b0; m_rdv = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wr_log.delete(); wa_log.delete(); wb_log.delete(); we_log.delete(); wr_cyc.delete();
    rd_log.delete(); rd_cyc.delete(); rv_host.delete(); rv_data.delete(); rv_cyc.delete();
    wr_hi_cnt = 0; h1_unwait = 0;
    @(posedge clk); #1;
  endtask

  task automatic host_write(input int h, input logic [31:0] addr, input int len,
                            input logic [31:0] base, output int accepted);
    int n = 0;
    int c = 0;
    @(posedge clk); #1;
    h_write[h] = 1'b1; h_addr[h] = addr; h_bc[h] = 6'(len); h_wdata[h] = base; h_be[h] = 4'hF;
    while (n < len && c < 200) begin
      @(negedge clk); c++;
      if (!h_wait[h]) begin
        n++;
        @(posedge clk); #1;
        if (n < len) h_wdata[h] = base + 32'(n);
        else         h_write[h] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    h_write[h] = 1'b0;
    accepted = n;
  endtask

  task automatic host_read(input int h, input logic [31:0] addr, input int len, output bit ok);
    int c = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    h_read[h] = 1'b1; h_addr[h] = addr; h_bc[h] = 6'(len); h_be[h] = 4'hF;
    while (!ok && c < 300) begin
      @(negedge clk); c++;
      if (!h_wait[h]) ok = 1'b1;
      @(posedge clk); #1;
    end
    h_read[h] = 1'b0;
  endtask

  task automatic agent_return(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_rdv = 1'b1; m_rdata = base + 32'(i);
    end
    @(posedge clk); #1;
    m_rdv = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++; if (m_write !== 1'b0) $display("FAIL reset_m_write: got %b want 0", m_write); else passed++;
    checks++; if (m_read !== 1'b0) $display("FAIL reset_m_read: got %b want 0", m_read); else passed++;
    checks++; if (m_address !== 32'h0) $display("FAIL reset_m_address: got %h want 0", m_address); else passed++;
    checks++; if (h_wait !== 2'b11) $display("FAIL reset_waitrequest: got %b want 11", h_wait); else passed++;
    checks++; if (h_rdv !== 2'b00) $display("FAIL reset_readdatavalid: got %b want 00", h_rdv); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_write_burst();
    int acc;
    int req_cyc;
    sel = 1'b0;
    do_reset();
    req_cyc = cyc + 1;
    host_write(0, 32'h100, 8, 32'hA000_0000, acc);
    checks++; if (acc !== 8) $display("FAIL wr8_accepted: got %0d want 8", acc); else passed++;
    checks++; if (wr_hi_cnt !== 8) $display("FAIL wr8_m_write_cycles: got %0d want 8", wr_hi_cnt); else passed++;
    checks++; if (wr_log.size() !== 8) $display("FAIL wr8_beats: got %0d want 8", wr_log.size()); else passed++;
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== 32'hA000_0000 + 32'(i)) $display("FAIL wr8_data[%0d]: got %h want %h", i, wr_log[i], 32'hA000_0000 + 32'(i));
      else passed++;
    end
    if (wr_log.size() > 0) begin
      checks++; if (wa_log[0] !== 32'h100) $display("FAIL wr8_address: got %h want 100", wa_log[0]); else passed++;
      checks++; if (wb_log[0] !== 6'd8) $display("FAIL wr8_burstcount: got %0d want 8", wb_log[0]); else passed++;
      checks++; if (we_log[0] !== 4'hF) $display("FAIL wr8_byteenable: got %h want f", we_log[0]); else passed++;
      checks++; if (wr_cyc[0] !== req_cyc + 1) $display("FAIL wr8_latency: got cycle %0d want %0d", wr_cyc[0], req_cyc + 1); else passed++;
    end
    checks++; if (h1_unwait !== 0) $display("FAIL wr8_h1_waitrequest: got %0d low cycles want 0", h1_unwait); else passed++;
    checks++; if (m_write !== 1'b0 || h_wait !== 2'b11) $display("FAIL wr8_idle_after: got m_write=%b wait=%b want 0/11", m_write, h_wait); else passed++;
  endtask

  task automatic test_round_robin();
    int a0, a1, b0, b1;
    logic [31:0] exp [8] = '{32'hA000_0000, 32'hA000_0001, 32'hB000_0000, 32'hB000_0001,
                             32'hA100_0000, 32'hA100_0001, 32'hB100_0000, 32'hB100_0001};
    sel = 1'b0;
    do_reset();
    fork
      host_write(0, 32'h200, 2, 32'hA000_0000, a0);
      host_write(1, 32'h300, 2, 32'hB000_0000, b0);
    join
    fork
      host_write(0, 32'h200, 2, 32'hA100_0000, a1);
      host_write(1, 32'h300, 2, 32'hB100_0000, b1);
    join
    checks++; if (wr_log.size() !== 8) $display("FAIL rr_beats: got %0d want 8", wr_log.size()); else passed++;
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== exp[i]) $display("FAIL rr_order[%0d]: got %h want %h", i, wr_log[i], exp[i]);
      else passed++;
    end
    if (wr_cyc.size() >= 3) begin
      checks++; if (wr_cyc[2] - wr_cyc[1] !== 2) $display("FAIL rr_idle_gap: got %0d want 2", wr_cyc[2] - wr_cyc[1]); else passed++;
    end
  endtask

  task automatic test_priority();
    int acc;
    bit ok;
    sel = 1'b1;
    do_reset();
    fork
      host_write(0, 32'h500, 1, 32'hC000_0000, acc);
      host_read(1, 32'h600, 1, ok);
    join
    checks++; if (ok !== 1'b1 || rd_cyc.size() !== 1 || wr_cyc.size() !== 1)
      $display("FAIL pri_tie_done: got ok=%b rd=%0d wr=%0d want 1/1/1", ok, rd_cyc.size(), wr_cyc.size()); else passed++;
    if (rd_cyc.size() == 1 && wr_cyc.size() == 1) begin
      checks++; if (wr_cyc[0] - rd_cyc[0] !== 2) $display("FAIL pri_tie_order: got write-read %0d want 2", wr_cyc[0] - rd_cyc[0]); else passed++;
    end
    do_reset();
    fork
      host_write(0, 32'h700, 8, 32'hC100_0000, acc);
      begin repeat (4) @(posedge clk); host_read(1, 32'h800, 4, ok); end
    join
    checks++; if (wr_log.size() !== 8 || rd_cyc.size() !== 1)
      $display("FAIL pri_mid_counts: got wr=%0d rd=%0d want 8/1", wr_log.size(), rd_cyc.size()); else passed++;
    if (wr_cyc.size() == 8 && rd_cyc.size() == 1) begin
      checks++; if (wr_cyc[7] - wr_cyc[0] !== 7) $display("FAIL pri_mid_contiguous: got span %0d want 7", wr_cyc[7] - wr_cyc[0]); else passed++;
      checks++; if (rd_cyc[0] - wr_cyc[7] !== 2) $display("FAIL pri_mid_read_after: got %0d want 2", rd_cyc[0] - wr_cyc[7]); else passed++;
      checks++; if (rd_log[0] !== 32'h800) $display("FAIL pri_mid_read_addr: got %h want 800", rd_log[0]); else passed++;
    end
  endtask

  task automatic test_pending_full();
    bit ok;
    int n0 = 0, n1 = 0;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_read(1, 32'h1000 + 32'(i) * 32'h100, 8, ok);
      checks++; if (ok !== 1'b1) $display("FAIL pend_read%0d_accept: got %b want 1", i, ok); else passed++;
    end
    fork
      host_read(1, 32'h2000, 1, ok);
      begin repeat (5) @(posedge clk); agent_return(32, 32'hE000_0000); end
    join
    checks++; if (ok !== 1'b1 || rd_cyc.size() !== 5) $display("FAIL pend_fifth_accept: got ok=%b cmds=%0d want 1/5", ok, rd_cyc.size()); else passed++;
    if (rd_cyc.size() == 5 && rv_cyc.size() >= 8) begin
      checks++; if (rd_cyc[4] - rv_cyc[7] !== 2) $display("FAIL pend_fifth_stall: got %0d want 2", rd_cyc[4] - rv_cyc[7]); else passed++;
    end
    foreach (rv_host[i]) if (rv_host[i] == 0) n0++; else n1++;
    checks++; if (n1 !== 32) $display("FAIL pend_h1_beats: got %0d want 32", n1); else passed++;
    checks++; if (n0 !== 0) $display("FAIL pend_h0_beats: got %0d want 0", n0); else passed++;
    if (rv_data.size() == 32) begin
      checks++; if (rv_data[31] !== 32'hE000_001F) $display("FAIL pend_last_data: got %h want e000001f", rv_data[31]); else passed++;
    end
    checks++; if (err !== 1'b0) $display("FAIL pend_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_interleave();
    bit ok0, ok1;
    int exp_host [5] = '{0, 0, 1, 1, 1};
    sel = 1'b0;
    do_reset();
    fork
      begin host_read(0, 32'h300, 2, ok0); host_read(1, 32'h400, 3, ok1); end
      begin repeat (4) @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          m_rdv = 1'b1; m_rdata = 32'hD0 + 32'(i);
          @(posedge clk); #1;
        end
        m_rdv = 1'b0;
      end
    join
    checks++; if (rv_host.size() !== 5) $display("FAIL intl_beats: got %0d want 5", rv_host.size()); else passed++;
    for (int i = 0; i < 5 && i < rv_host.size(); i++) begin
      checks++;
      if (rv_host[i] !== exp_host[i] || rv_data[i] !== 32'hD0 + 32'(i))
        $display("FAIL intl_route[%0d]: got host %0d data %h want host %0d data %h", i, rv_host[i], rv_data[i], exp_host[i], 32'hD0 + 32'(i));
      else passed++;
    end
    checks++; if (err !== 1'b0) $display("FAIL intl_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_back_to_back_stall();
    int acc;
    logic [15:0] pat = 16'b0110_1011_0010_1101;
    sel = 1'b0;
    do_reset();
    fork
      host_write(0, 32'h900, 8, 32'hF000_0000, acc);
      begin
        for (int i = 0; i < 24; i++) begin @(posedge clk); #1 m_wait = pat[i % 16]; end
        @(posedge clk); #1 m_wait = 1'b0;
      end
    join
    checks++; if (acc !== 8) $display("FAIL stall_host_accepted: got %0d want 8", acc); else passed++;
    checks++; if (wr_log.size() !== 8) $display("FAIL stall_agent_beats: got %0d want 8", wr_log.size()); else passed++;
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== 32'hF000_0000 + 32'(i)) $display("FAIL stall_data[%0d]: got %h want %h", i, wr_log[i], 32'hF000_0000 + 32'(i));
      else passed++;
    end
    checks++; if (m_write !== 1'b0 || h_wait !== 2'b11) $display("FAIL stall_idle_after: got m_write=%b wait=%b want 0/11", m_write, h_wait); else passed++;
  endtask

  task automatic test_conflict();
    sel = 1'b0;
    do_reset();
    @(posedge clk); #1;
    h_write[0] = 1'b1; h_read[0] = 1'b1; h_bc[0] = 6'd1; h_addr[0] = 32'hA00; h_wdata[0] = 32'h55;
    @(posedge clk); @(negedge clk);
    checks++; if (m_write !== 1'b1 || m_read !== 1'b0) $display("FAIL conflict_write_wins: got w=%b r=%b want 1/0", m_write, m_read); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL conflict_err: got %b want 1", err); else passed++;
    @(posedge clk); #1;
    h_write[0] = 1'b0; h_read[0] = 1'b0;
  endtask

  task automatic test_reset_orphan();
    bit ok;
    sel = 1'b0;
    do_reset();
    host_read(1, 32'hB00, 2, ok);
    @(posedge clk); #1;
    h_write[0] = 1'b1; h_bc[0] = 6'd8; h_addr[0] = 32'hC00; h_wdata[0] = 32'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_write !== 1'b1) $display("FAIL rst_mid_precond: got m_write=%b want 1", m_write); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m_write !== 1'b0) $display("FAIL rst_mid_m_write: got %b want 0", m_write); else passed++;
    checks++; if (h_wait !== 2'b11) $display("FAIL rst_mid_waitrequest: got %b want 11", h_wait); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", err); else passed++;
    h_write[0] = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    m_rdv = 1'b1; m_rdata = 32'hBAD;
    #1;
    checks++; if (h_rdv !== 2'b00) $display("FAIL orphan_dropped: got %b want 00", h_rdv); else passed++;
    @(posedge clk); #1 m_rdv = 1'b0;
    checks++; if (err !== 1'b1) $display("FAIL orphan_err: got %b want 1", err); else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) $display("FAIL orphan_err_sticky: got %b want 1", err); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_round_robin();
    test_priority();
    test_pending_full();
    test_interleave();
    test_back_to_back_stall();
    test_conflict();
    test_reset_orphan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
